// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap controller.
package trap_ctrl_pkg;

    // CSR addresses touched by the trap sequencer
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Exception cause codes
    localparam int unsigned CAUSE_W          = 4;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M    = 4'd11;

    // mstatus bit positions
    localparam int unsigned MST_MIE    = 3;
    localparam int unsigned MST_MPIE   = 7;
    localparam int unsigned MST_MPP_LO = 11;
    localparam int unsigned MST_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_MST    = 3'd1,
        WR_MST    = 3'd2,
        WR_MEPC   = 3'd3,
        WR_MCAUSE = 3'd4,
        RD_MTVEC  = 3'd5,
        RD_MEPC   = 3'd6,
        REDIRECT  = 3'd7
    } trap_state_e;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_MRET = 1'b1
    } trap_kind_e;

    // CSR command (without data, whose width follows XLEN)
    typedef struct packed {
        logic        en;
        logic        we;
        logic [11:0] idx;
    } csr_cmd_t;

    // Cause selection: illegal beats ebreak beats ecall
    function automatic logic [CAUSE_W-1:0] trap_cause(input logic illegal, input logic ebreak);
        if (illegal) begin
            return CAUSE_ILLEGAL;
        end else if (ebreak) begin
            return CAUSE_BREAKPOINT;
        end
        return CAUSE_ECALL_M;
    endfunction

endpackage

// File: rtl/trap_ctrl_csr_port_mux.sv
// Arbitrates the single CSR port between the pipeline and the trap sequencer.
module trap_ctrl_csr_port_mux
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            trap_own_i,
    input  logic            suppress_i,
    input  csr_cmd_t        trap_cmd_i,
    input  logic [XLEN-1:0] trap_wdata_i,
    input  csr_cmd_t        pipe_cmd_i,
    input  logic [XLEN-1:0] pipe_wdata_i,
    output csr_cmd_t        port_cmd_o,
    output logic [XLEN-1:0] port_wdata_o
);

    // Trap owns the port when busy; a trapping instruction loses its own CSR access
    always_comb begin
        port_cmd_o   = pipe_cmd_i;
        port_wdata_o = pipe_wdata_i;
        if (trap_own_i) begin
            port_cmd_o   = trap_cmd_i;
            port_wdata_o = trap_wdata_i;
        end else if (suppress_i) begin
            port_cmd_o.en = 1'b0;
            port_cmd_o.we = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer driving CSR updates and a PC redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            instr_valid_i,
    input  logic            id_ecall_i,
    input  logic            id_ebreak_i,
    input  logic            id_mret_i,
    input  logic            id_ilegl_instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pipe_csr_en_i,
    input  logic            pipe_csr_we_i,
    input  logic [11:0]     pipe_csr_idx_i,
    input  logic [XLEN-1:0] pipe_csr_wdata_i,
    output logic            csr_en_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_idx_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    trap_state_e        state_q;
    trap_kind_e         kind_q;
    logic [XLEN-1:0]    pc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    mst_q;
    logic               redirect_valid_q;
    logic [XLEN-1:0]    redirect_pc_q;

    logic               trap_any;
    logic               detect_c;
    logic [XLEN-1:0]    mst_wdata;
    csr_cmd_t           trap_cmd;
    logic [XLEN-1:0]    trap_wdata;
    csr_cmd_t           pipe_cmd;
    csr_cmd_t           port_cmd;

    // Detection is only possible in IDLE and never while reset is held
    assign trap_any = id_ilegl_instr_i | id_ebreak_i | id_ecall_i;
    assign detect_c = rst_n_i & (state_q == IDLE) & instr_valid_i & (trap_any | id_mret_i);

    // Sequencer state, latched context and redirect outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= IDLE;
            kind_q           <= KIND_TRAP;
            pc_q             <= '0;
            cause_q          <= '0;
            mst_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (detect_c) begin
                        pc_q    <= pc_i;
                        state_q <= RD_MST;
                        if (trap_any) begin
                            kind_q  <= KIND_TRAP;
                            cause_q <= trap_cause(id_ilegl_instr_i, id_ebreak_i);
                        end else begin
                            kind_q  <= KIND_MRET;
                            cause_q <= '0;
                        end
                    end
                end
                RD_MST: begin
                    mst_q   <= csr_rdata_i;
                    state_q <= WR_MST;
                end
                WR_MST: begin
                    state_q <= (kind_q == KIND_TRAP) ? WR_MEPC : RD_MEPC;
                end
                WR_MEPC: begin
                    state_q <= WR_MCAUSE;
                end
                WR_MCAUSE: begin
                    state_q <= RD_MTVEC;
                end
                RD_MTVEC: begin
                    redirect_pc_q    <= {csr_rdata_i[XLEN-1:2], 2'b00};
                    redirect_valid_q <= 1'b1;
                    state_q          <= REDIRECT;
                end
                RD_MEPC: begin
                    redirect_pc_q    <= csr_rdata_i;
                    redirect_valid_q <= 1'b1;
                    state_q          <= REDIRECT;
                end
                REDIRECT: begin
                    redirect_pc_q    <= '0;
                    redirect_valid_q <= 1'b0;
                    state_q          <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // New mstatus: trap stacks MIE into MPIE, mret restores it; MPP forced to M
    always_comb begin
        mst_wdata = mst_q;
        if (kind_q == KIND_TRAP) begin
            mst_wdata[MST_MPIE] = mst_q[MST_MIE];
            mst_wdata[MST_MIE]  = 1'b0;
        end else begin
            mst_wdata[MST_MIE]  = mst_q[MST_MPIE];
            mst_wdata[MST_MPIE] = 1'b1;
        end
        mst_wdata[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    end

    // CSR access issued by the sequencer in each state
    always_comb begin
        trap_cmd   = '0;
        trap_wdata = '0;
        case (state_q)
            RD_MST: begin
                trap_cmd.en  = 1'b1;
                trap_cmd.idx = CSR_MSTATUS;
            end
            WR_MST: begin
                trap_cmd.en  = 1'b1;
                trap_cmd.we  = 1'b1;
                trap_cmd.idx = CSR_MSTATUS;
                trap_wdata   = mst_wdata;
            end
            WR_MEPC: begin
                trap_cmd.en  = 1'b1;
                trap_cmd.we  = 1'b1;
                trap_cmd.idx = CSR_MEPC;
                trap_wdata   = pc_q;
            end
            WR_MCAUSE: begin
                trap_cmd.en  = 1'b1;
                trap_cmd.we  = 1'b1;
                trap_cmd.idx = CSR_MCAUSE;
                trap_wdata   = XLEN'(cause_q);
            end
            RD_MTVEC: begin
                trap_cmd.en  = 1'b1;
                trap_cmd.idx = CSR_MTVEC;
            end
            RD_MEPC: begin
                trap_cmd.en  = 1'b1;
                trap_cmd.idx = CSR_MEPC;
            end
            default: begin
            end
        endcase
    end

    assign pipe_cmd.en  = pipe_csr_en_i;
    assign pipe_cmd.we  = pipe_csr_we_i;
    assign pipe_cmd.idx = pipe_csr_idx_i;

    trap_ctrl_csr_port_mux #(
        .XLEN (XLEN)
    ) u_csr_port_mux (
        .trap_own_i   (state_q != IDLE),
        .suppress_i   (detect_c),
        .trap_cmd_i   (trap_cmd),
        .trap_wdata_i (trap_wdata),
        .pipe_cmd_i   (pipe_cmd),
        .pipe_wdata_i (pipe_csr_wdata_i),
        .port_cmd_o   (port_cmd),
        .port_wdata_o (csr_wdata_o)
    );

    assign csr_en_o         = port_cmd.en;
    assign csr_we_o         = port_cmd.we;
    assign csr_idx_o        = port_cmd.idx;
    assign stall_o          = (state_q != IDLE) | detect_c;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: CSR file model, directed scenarios, then randomized events.
module tb_trap_ctrl;

    localparam logic [11:0] IDX_MSCRATCH = 12'h340;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        ecall, ebreak, mret, ilegl;
    logic [63:0] pc;
    logic        pipe_en, pipe_we;
    logic [11:0] pipe_idx;
    logic [63:0] pipe_wdata;
    logic        csr_en, csr_we;
    logic [11:0] csr_idx;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        stall, redir_v;
    logic [63:0] redir_pc;

    // CSR file model, written only by the stimulus process
    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch;

    int tests = 0;
    int fails = 0;
    logic [63:0] last_redir;
    int          last_lat;

    trap_ctrl #(.XLEN(64)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .instr_valid_i    (instr_valid),
        .id_ecall_i       (ecall),
        .id_ebreak_i      (ebreak),
        .id_mret_i        (mret),
        .id_ilegl_instr_i (ilegl),
        .pc_i             (pc),
        .pipe_csr_en_i    (pipe_en),
        .pipe_csr_we_i    (pipe_we),
        .pipe_csr_idx_i   (pipe_idx),
        .pipe_csr_wdata_i (pipe_wdata),
        .csr_en_o         (csr_en),
        .csr_we_o         (csr_we),
        .csr_idx_o        (csr_idx),
        .csr_wdata_o      (csr_wdata),
        .csr_rdata_i      (csr_rdata),
        .stall_o          (stall),
        .redirect_valid_o (redir_v),
        .redirect_pc_o    (redir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational CSR read port
    always_comb begin
        case (csr_idx)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            12'h340: csr_rdata = m_mscratch;
            default: csr_rdata = 64'h0;
        endcase
    end

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the CSR write presented before the edge lands in the model after it
    task automatic tick();
        logic        w;
        logic [11:0] wi;
        logic [63:0] wd;
        w  = csr_en & csr_we;
        wi = csr_idx;
        wd = csr_wdata;
        @(posedge clk);
        #1;
        if (w) begin
            case (wi)
                12'h300: m_mstatus  = wd;
                12'h305: m_mtvec    = wd;
                12'h341: m_mepc     = wd;
                12'h342: m_mcause   = wd;
                12'h340: m_mscratch = wd;
                default: ;
            endcase
        end
    endtask

    task automatic drive_idle();
        instr_valid = 1'b0;
        ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; ilegl = 1'b0;
        pipe_en = 1'b0; pipe_we = 1'b0;
        pipe_idx = IDX_MSCRATCH;
        pipe_wdata = 64'h0;
    endtask

    // One decoded instruction plus the full sequence it triggers, checked against the model
    task automatic run_event(input logic v, input logic il, input logic eb, input logic ec,
                             input logic mr, input logic [63:0] pc_v, input int noise);
        logic        det, trp, pe, pw, exp_we;
        logic [63:0] exp_mst, exp_pc, exp_mepc, exp_mcause, exp_scr, pd;
        logic [11:0] exp_idx;
        int          lat;
        trp = v & (il | eb | ec);
        det = v & (il | eb | ec | mr);
        if (trp) begin
            exp_mst    = (m_mstatus & ~64'h1888) | 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
            exp_pc     = {m_mtvec[63:2], 2'b00};
            exp_mepc   = pc_v;
            exp_mcause = il ? 64'd2 : (eb ? 64'd3 : 64'd11);
            lat        = 6;
        end else begin
            exp_mst    = (m_mstatus & ~64'h1888) | 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
            exp_pc     = m_mepc;
            exp_mepc   = m_mepc;
            exp_mcause = m_mcause;
            lat        = 4;
        end
        if (!det) begin
            exp_mst  = m_mstatus;
            exp_mepc = m_mepc;
        end
        pe = 1'($urandom_range(0, 1));
        pw = 1'($urandom_range(0, 1));
        pd = rand64();
        instr_valid = v; ilegl = il; ebreak = eb; ecall = ec; mret = mr;
        pc = pc_v;
        pipe_en = pe; pipe_we = pw; pipe_idx = IDX_MSCRATCH; pipe_wdata = pd;
        #2;
        chk("det_stall", 64'(stall), 64'(det));
        chk("det_csr_en", 64'(csr_en), 64'(det ? 1'b0 : pe));
        if (!det) begin
            chk("pass_we", 64'(csr_we), 64'(pw));
            chk("pass_idx", 64'(csr_idx), 64'(IDX_MSCRATCH));
            chk("pass_wdata", csr_wdata, pd);
        end
        chk("det_redir_v", 64'(redir_v), 64'h0);
        exp_scr = (!det && pe && pw) ? pd : m_mscratch;
        tick();
        if (det) begin
            for (int c = 1; c <= lat; c++) begin
                drive_idle();
                if (noise == 1) begin
                    instr_valid = 1'($urandom_range(0, 1));
                    ilegl  = 1'($urandom_range(0, 1));
                    ebreak = 1'($urandom_range(0, 1));
                    ecall  = 1'($urandom_range(0, 1));
                    mret   = 1'($urandom_range(0, 1));
                    pc     = rand64();
                    pipe_en = 1'b1; pipe_we = 1'b1; pipe_wdata = rand64();
                end else if (noise == 2 && c == 3) begin
                    instr_valid = 1'b1;
                    ecall = 1'b1;
                    pc = 64'hdead_0000;
                end
                #2;
                chk("busy_stall", 64'(stall), 64'h1);
                chk("busy_redir_v", 64'(redir_v), 64'(c == lat));
                chk("busy_redir_pc", redir_pc, (c == lat) ? exp_pc : 64'h0);
                if (c == lat) begin
                    last_redir = redir_pc;
                    last_lat   = c;
                end
                chk("busy_csr_en", 64'(csr_en), 64'(c < lat));
                if (c < lat) begin
                    exp_we  = trp ? (c >= 2 && c <= 4) : (c == 2);
                    exp_idx = (c <= 2) ? 12'h300 : (c == 3) ? 12'h341 :
                              (c == 4) ? 12'h342 : 12'h305;
                    chk("busy_csr_we", 64'(csr_we), 64'(exp_we));
                    chk("busy_csr_idx", 64'(csr_idx), 64'(exp_idx));
                end
                tick();
            end
        end
        drive_idle();
        #2;
        chk("post_redir_v", 64'(redir_v), 64'h0);
        chk("post_redir_pc", redir_pc, 64'h0);
        chk("post_stall", 64'(stall), 64'h0);
        chk("mstatus", m_mstatus, exp_mst);
        chk("mepc", m_mepc, exp_mepc);
        chk("mcause", m_mcause, exp_mcause);
        chk("mscratch", m_mscratch, exp_scr);
        tick();
    endtask

    initial begin
        m_mstatus = 64'h0; m_mtvec = 64'h0; m_mepc = 64'h0; m_mcause = 64'h0; m_mscratch = 64'h0;
        last_redir = 64'h0;
        last_lat = 0;
        drive_idle();
        pc = 64'h0;

        // Reset held: no stall even with a trap flag, port mirrors the pipeline
        rst_n = 1'b0;
        instr_valid = 1'b1; ecall = 1'b1;
        pipe_en = 1'b1; pipe_we = 1'b0; pipe_wdata = 64'h1234;
        #3;
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_redir_v", 64'(redir_v), 64'h0);
        chk("rst_redir_pc", redir_pc, 64'h0);
        chk("rst_csr_en", 64'(csr_en), 64'h1);
        chk("rst_csr_idx", 64'(csr_idx), 64'(IDX_MSCRATCH));
        chk("rst_csr_wdata", csr_wdata, 64'h1234);
        drive_idle();
        tick();
        rst_n = 1'b1;

        // Pipeline csrrw to mscratch in IDLE
        pipe_en = 1'b1; pipe_we = 1'b1; pipe_idx = IDX_MSCRATCH; pipe_wdata = 64'h55;
        #2;
        chk("csrrw_we", 64'(csr_we), 64'h1);
        chk("csrrw_idx", 64'(csr_idx), 64'h340);
        chk("csrrw_wdata", csr_wdata, 64'h55);
        chk("csrrw_stall", 64'(stall), 64'h0);
        tick();
        drive_idle();
        chk("csrrw_mscratch", m_mscratch, 64'h55);

        // ecall trap entry
        m_mstatus = 64'h8; m_mtvec = 64'h8000_0101; m_mcause = 64'h0;
        run_event(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0010, 0);
        chk("ecall_mstatus", m_mstatus, 64'h1880);
        chk("ecall_mepc", m_mepc, 64'h8000_0010);
        chk("ecall_mcause", m_mcause, 64'd11);
        chk("ecall_redir", last_redir, 64'h8000_0100);
        chk("ecall_lat", 64'(last_lat), 64'd6);

        // mret return
        m_mstatus = 64'h80; m_mepc = 64'h8000_0200;
        run_event(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0300, 0);
        chk("mret_mstatus", m_mstatus, 64'h1888);
        chk("mret_redir", last_redir, 64'h8000_0200);
        chk("mret_lat", 64'(last_lat), 64'd4);

        // Priority cases
        run_event(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0400, 0);
        chk("prio_ill_ecall", m_mcause, 64'd2);
        run_event(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0500, 0);
        chk("prio_mret_ebreak", m_mcause, 64'd3);
        chk("prio_mret_ebreak_lat", 64'(last_lat), 64'd6);

        // ecall during WR_MEPC is dropped; only one redirect follows
        run_event(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0600, 2);
        for (int i = 0; i < 8; i++) begin
            #2;
            chk("nested_no_redir", 64'(redir_v), 64'h0);
            chk("nested_no_stall", 64'(stall), 64'h0);
            tick();
        end

        // Flags without instr_valid are ignored
        run_event(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0700, 0);

        // Reset asserted during WR_MCAUSE
        m_mstatus = 64'h8; m_mtvec = 64'h8000_0800; m_mepc = 64'h1111; m_mcause = 64'hdead;
        instr_valid = 1'b1; ecall = 1'b1; pc = 64'h8000_0040;
        #2;
        chk("rstmid_det_stall", 64'(stall), 64'h1);
        tick();
        drive_idle();
        repeat (3) tick();
        #1;
        chk("rstmid_in_mcause", 64'(csr_idx), 64'h342);
        rst_n = 1'b0;
        pipe_en = 1'b1; pipe_we = 1'b0; pipe_idx = IDX_MSCRATCH;
        #1;
        chk("rstmid_stall", 64'(stall), 64'h0);
        chk("rstmid_redir_v", 64'(redir_v), 64'h0);
        chk("rstmid_csr_en", 64'(csr_en), 64'h1);
        chk("rstmid_csr_we", 64'(csr_we), 64'h0);
        chk("rstmid_csr_idx", 64'(csr_idx), 64'(IDX_MSCRATCH));
        tick();
        rst_n = 1'b1;
        #2;
        chk("rstrel_stall", 64'(stall), 64'h0);
        chk("rstrel_csr_idx", 64'(csr_idx), 64'(IDX_MSCRATCH));
        drive_idle();
        for (int i = 0; i < 8; i++) begin
            tick();
            #2;
            chk("rstrel_no_redir", 64'(redir_v), 64'h0);
            chk("rstrel_no_stall", 64'(stall), 64'h0);
        end
        tick();
        chk("rstmid_mcause_kept", m_mcause, 64'hdead);
        chk("rstmid_mstatus", m_mstatus, 64'h1880);
        chk("rstmid_mepc", m_mepc, 64'h8000_0040);

        // Randomized events with noise on every busy cycle
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_mstatus = rand64();
                m_mtvec   = rand64();
                m_mepc    = rand64();
            end
            run_event(1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 2) == 0),
                      rand64(), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN (64), data/PC width.
REQ-002 SHALL have ports: clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have instr_valid_i  in  1  decoded instruction valid this cycle.
REQ-005 SHALL have id_ecall_i, id_ebreak_i, id_mret_i, id_ilegl_instr_i  in  1 each  decoder exception flags.
REQ-006 SHALL have pc_i  in  XLEN  PC of the decoded instruction.
REQ-007 SHALL have pipe_csr_en_i, pipe_csr_we_i  in  1; pipe_csr_idx_i  in  12; pipe_csr_wdata_i  in  XLEN  pipeline CSR request.
REQ-008 SHALL have csr_en_o, csr_we_o  out  1; csr_idx_o  out  12; csr_wdata_o  out  XLEN  arbitrated CSR port.
REQ-009 SHALL have csr_rdata_i  in  XLEN  CSR read data, combinational, same cycle as csr_idx_o.
REQ-010 SHALL have stall_o  out  1  freeze fetch/decode; redirect_valid_o  out  1; redirect_pc_o  out  XLEN.

Function
REQ-011 SHALL use FSM states IDLE, RD_MST, WR_MST, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, REDIRECT.
REQ-012 In IDLE, instr_valid_i with illegal/ebreak/ecall SHALL latch pc_i and cause, go to RD_MST with kind=TRAP; with id_mret_i only, go to RD_MST with kind=MRET.
REQ-013 Cause priority SHALL be illegal (2) > ebreak (3) > ecall (11); mret is ignored if any trap flag is also set.
REQ-014 TRAP path SHALL be RD_MST -> WR_MST -> WR_MEPC -> WR_MCAUSE -> RD_MTVEC -> REDIRECT -> IDLE (6 cycles after detection).
REQ-015 MRET path SHALL be RD_MST -> WR_MST -> RD_MEPC -> REDIRECT -> IDLE (4 cycles after detection).
REQ-016 RD_* states SHALL drive csr_en_o=1, csr_we_o=0, index 0x300/0x305/0x341 and register csr_rdata_i at the edge.
REQ-017 WR_MST for TRAP SHALL write mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP[12:11]=2'b11, other bits unchanged.
REQ-018 WR_MST for MRET SHALL write MIE=old MPIE, MPIE=1, MPP=2'b11, other bits unchanged.
REQ-019 WR_MEPC SHALL write latched PC to 0x341; WR_MCAUSE SHALL write zero-extended cause to 0x342.
REQ-020 REDIRECT SHALL assert redirect_valid_o for exactly one cycle with redirect_pc_o = {mtvec[XLEN-1:2],2'b00} (TRAP) or mepc (MRET); redirect_pc_o SHALL be 0 otherwise.
REQ-021 stall_o SHALL be 1 in every non-IDLE state and combinationally in the IDLE detection cycle.
REQ-022 In IDLE, CSR port SHALL pass pipe_csr_* through unchanged; in non-IDLE states pipe_csr_* SHALL be ignored (trap owns port).
REQ-023 In the IDLE detection cycle, pipeline CSR request SHALL be suppressed (csr_en_o=0) since the instruction traps.
REQ-024 Exception flags arriving while not IDLE SHALL be ignored; no queuing.
REQ-025 Flags with instr_valid_i=0 SHALL be ignored.

Reset
REQ-026 Asserting rst_n_i at any time, including mid-sequence, SHALL force IDLE and clear latched PC, cause, kind and read registers to 0 immediately.
REQ-027 During reset, stall_o, redirect_valid_o, redirect_pc_o SHALL be 0 and CSR port SHALL mirror pipe_csr_* (IDLE rule); partial CSR updates are not rolled back.

Structure
REQ-028 CSR addresses (0x300, 0x305, 0x341, 0x342), cause codes, mstatus bit positions and state encodings SHALL live in shared defines.v.
REQ-029 SHALL be one module; CSR port mux MAY be a sub-module csr_port_mux.

Verification
REQ-030 ecall at pc 0x8000_0010, mstatus=0x8, mtvec=0x8000_0101 -> writes mstatus 0x1880, mepc 0x8000_0010, mcause 11; redirect 0x8000_0100 at cycle +6.
REQ-031 mret with mstatus=0x80, mepc=0x8000_0200 -> writes mstatus 0x1888; redirect 0x8000_0200 at cycle +4, stall_o high cycles 0..4.
REQ-032 illegal+ecall same cycle -> mcause 2; mret+ebreak -> trap path, mcause 3.
REQ-033 ecall arriving during WR_MEPC of prior trap -> ignored, exactly one redirect.
REQ-034 rst_n_i low during WR_MCAUSE -> IDLE next cycle, no redirect, stall_o 0, pipeline CSR passthrough restored.
REQ-035 IDLE with pipe csrrw to 0x340 wdata 0x55 -> csr_we_o=1, idx 0x340, wdata 0x55, stall_o 0.
